// File: rtl/fnd_scan_controller.sv
// Four-digit FND scan scheduler: walks digits 0..3 with a dwell and optional dead-time blank,
// swapping in a new display word only at frame boundaries. Define FND_LZB_EN for leading-zero blanking.
module fnd_scan_controller #(
  parameter int DIV   = 100000,
  parameter int DEAD  = 16,
  parameter int CNT_W = 17
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_run,
  input  logic        i_load,
  input  logic [15:0] i_bcd,
  output logic [1:0]  o_digitSelect,
  output logic [3:0]  o_value,
  output logic        o_en,
  output logic        o_frame
);

  typedef enum logic [1:0] {S_OFF, S_SHOW, S_DEAD} state_t;

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'((DEAD > 0) ? DEAD - 1 : 0);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        sel_q, sel_d;
  logic [3:0]        value_q, value_d;
  logic              en_q, en_d;
  logic              frame_q, frame_d;
  logic [15:0]       shadow_q, shadow_d;
  logic [15:0]       active_q, active_d;
  logic              light_d;

  function automatic logic [3:0] nibble(input logic [15:0] w, input logic [1:0] k);
    return w[{k, 2'b00} +: 4];
  endfunction

`ifdef FND_LZB_EN
  // A digit stays dark only when it and every more-significant digit are zero.
  function automatic logic digit_lit(input logic [15:0] w, input logic [1:0] k);
    logic lit;
    case (k)
      2'd0:    lit = 1'b1;
      2'd1:    lit = |w[15:4];
      2'd2:    lit = |w[15:8];
      default: lit = |w[15:12];
    endcase
    return lit;
  endfunction
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    en_d     = en_q;
    frame_d  = 1'b0;
    shadow_d = i_load ? i_bcd : shadow_q;
    active_d = active_q;
    light_d  = 1'b0;

    case (state_q)
      S_OFF: begin
        active_d = shadow_q;
        cnt_d    = '0;
        sel_d    = 2'd0;
        state_d  = S_SHOW;
        light_d  = 1'b1;
      end
      S_SHOW: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          sel_d = 2'(sel_q + 2'd1);
          if (sel_q == 2'd3) begin
            frame_d  = 1'b1;
            // A load landing on the boundary must not be lost for a whole frame.
            active_d = i_load ? i_bcd : shadow_q;
          end
          if (DEAD > 0) begin
            state_d = S_DEAD;
            en_d    = 1'b0;
          end else begin
            light_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DEAD: begin
        if (cnt_q == DEAD_LAST) begin
          cnt_d   = '0;
          state_d = S_SHOW;
          light_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_OFF;
        cnt_d   = '0;
        sel_d   = 2'd0;
        en_d    = 1'b0;
      end
    endcase

    if (light_d) begin
`ifdef FND_LZB_EN
      en_d = digit_lit(active_d, sel_d);
`else
      en_d = 1'b1;
`endif
    end

    if (!i_run) begin
      state_d = S_OFF;
      cnt_d   = '0;
      sel_d   = 2'd0;
      en_d    = 1'b0;
      frame_d = 1'b0;
    end

    value_d = nibble(active_d, sel_d);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= S_OFF;
      cnt_q    <= '0;
      sel_q    <= 2'd0;
      value_q  <= 4'd0;
      en_q     <= 1'b0;
      frame_q  <= 1'b0;
      shadow_q <= 16'd0;
      active_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      value_q  <= value_d;
      en_q     <= en_d;
      frame_q  <= frame_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign o_digitSelect = sel_q;
  assign o_value       = value_q;
  assign o_en          = en_q;
  assign o_frame       = frame_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Scoreboard bench for fnd_scan_controller: DIV=4 with DEAD=2 (dut0) and DEAD=0 (dut1).
module tb_fnd_scan_controller;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] val;
    logic       en;
    logic       fr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        load = 1'b0;
  logic [15:0] bcd = 16'h0;

  logic [1:0] sel0, sel1;
  logic [3:0] val0, val1;
  logic       en0, en1, fr0, fr1;

  exp_t q0[$];
  exp_t q1[$];
  bit   pend[2];
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  fnd_scan_controller #(.DIV(4), .DEAD(2), .CNT_W(3)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_load(load), .i_bcd(bcd),
    .o_digitSelect(sel0), .o_value(val0), .o_en(en0), .o_frame(fr0)
  );

  fnd_scan_controller #(.DIV(4), .DEAD(0), .CNT_W(3)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_load(load), .i_bcd(bcd),
    .o_digitSelect(sel1), .o_value(val1), .o_en(en1), .o_frame(fr1)
  );

  function automatic logic [3:0] nib(input logic [15:0] w, input int d);
    return 4'(w >> (4 * d));
  endfunction

  function automatic logic en_exp(input logic [15:0] w, input int d);
    logic lit;
    lit = (d == 0) || ((w >> (4 * d)) != 16'h0);
`ifndef FND_LZB_EN
    lit = 1'b1;
`endif
    return lit;
  endfunction

  task automatic add(input int which, input int s, input logic [3:0] v, input logic e, input logic f);
    exp_t x;
    x = {2'(s), v, e, f};
    if (which == 0) q0.push_back(x);
    else q1.push_back(x);
  endtask

  // One frame as seen from the first cycle of digit 0; nxt is the word latched at the boundary.
  task automatic push_frame(input int which, input logic [15:0] cur, input logic [15:0] nxt,
                            input int dead, input int n);
    int   k;
    int   nd;
    logic f;
    k = 0;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        if (k < n) begin
          f = pend[which];
          pend[which] = 1'b0;
          add(which, d, nib(cur, d), en_exp(cur, d), f);
          k++;
        end
      end
      for (int c = 0; c < dead; c++) begin
        if (k < n) begin
          nd = (d + 1) % 4;
          add(which, nd, nib((d == 3) ? nxt : cur, nd), 1'b0, (d == 3) && (c == 0));
          k++;
        end
      end
      if (dead == 0 && d == 3 && k == 16) pend[which] = 1'b1;
    end
  endtask

  task automatic chk(input string nm, input exp_t e, input exp_t a);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s vec%0d: got sel=%0d val=%h en=%b frame=%b, expected sel=%0d val=%h en=%b frame=%b",
               nm, nvec, a.sel, a.val, a.en, a.fr, e.sel, e.val, e.en, e.fr);
    end
  endtask

  always begin
    exp_t x;
    @(posedge clk);
    #1;
    if (q0.size() > 0) begin
      x = q0.pop_front();
      chk("dut0", x, {sel0, val0, en0, fr0});
    end
    if (q1.size() > 0) begin
      x = q1.pop_front();
      chk("dut1", x, {sel1, val1, en1, fr1});
    end
  end

  task automatic drive(input logic r, input logic rn, input logic ld, input logic [15:0] b);
    @(negedge clk);
    rst_n = r;
    run   = rn;
    load  = ld;
    bcd   = b;
  endtask

  task automatic reset_both();
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    add(0, 0, 4'h0, 1'b0, 1'b0);
    add(1, 0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin : stim
    logic        r_v, run_v, ld_v;
    logic [15:0] b_v;
    pend[0] = 1'b0;
    pend[1] = 1'b0;

    // Scan 0x1234, reload mid-frame, load on the boundary, stop in dead time, reset mid-dwell.
    reset_both();
    drive(1'b1, 1'b0, 1'b1, 16'h1234);
    add(0, 0, 4'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 16'h0);
    push_frame(0, 16'h1234, 16'h5A0F, 2, 24);
    push_frame(0, 16'h5A0F, 16'h9999, 2, 24);
    push_frame(0, 16'h9999, 16'h9999, 2, 24);
    push_frame(0, 16'h9999, 16'h9999, 2, 11);
    add(0, 0, 4'h9, 1'b0, 1'b0);
    add(0, 0, 4'h9, 1'b0, 1'b0);
    push_frame(0, 16'h9999, 16'h9999, 2, 24);
    push_frame(0, 16'h9999, 16'h9999, 2, 2);
    add(0, 0, 4'h0, 1'b0, 1'b0);
    add(0, 0, 4'h0, en_exp(16'h0, 0), 1'b0);
    for (int g = 1; g <= 112; g++) begin
      r_v = 1'b1; run_v = 1'b1; ld_v = 1'b0; b_v = 16'h0;
      case (g)
        7:       begin ld_v = 1'b1; b_v = 16'h5A0F; end
        46:      begin ld_v = 1'b1; b_v = 16'h9999; end
        83, 84:  run_v = 1'b0;
        111:     r_v = 1'b0;
        default: ;
      endcase
      drive(r_v, run_v, ld_v, b_v);
    end

    // No dead time: the enable never drops and digits step every dwell.
    reset_both();
    drive(1'b1, 1'b0, 1'b1, 16'h0001);
    add(1, 0, 4'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 16'h0);
    pend[1] = 1'b0;
    push_frame(1, 16'h0001, 16'h0001, 0, 24);
    push_frame(1, 16'h0001, 16'h0001, 0, 24);
    push_frame(1, 16'h0001, 16'h0001, 0, 1);
    for (int g = 1; g <= 48; g++) drive(1'b1, 1'b1, 1'b0, 16'h0);

    // Leading zeros: 0x0042, then an all-zero word.
    reset_both();
    drive(1'b1, 1'b0, 1'b1, 16'h0042);
    add(0, 0, 4'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 16'h0);
    push_frame(0, 16'h0042, 16'h0000, 2, 24);
    push_frame(0, 16'h0000, 16'h0000, 2, 24);
    for (int g = 1; g <= 47; g++) begin
      if (g == 3) drive(1'b1, 1'b1, 1'b1, 16'h0000);
      else        drive(1'b1, 1'b1, 1'b0, 16'h0);
    end

    repeat (3) @(negedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      nerr++;
      $display("FAIL drain: %0d/%0d expectations left, expected 0/0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
